wb_stage_unit: RTL and testbench
================================

Name: wb_stage_unit

Overview:
- Writeback stage. Sits on the read side of the memory/writeback pipeline register and consumes its outputs.
- Selects the final result: ALU data, memory data or the input-port value.
- Drives the register-file write port, the flag-register write and the two-beat PC reload used by RET/RTI (high half, then low half).
- Owns the external output port, which uses a valid/ready handshake and back-pressures the pipeline.

Parameters:
- DATA_W, 16, datapath width.
- RADDR_W, 3, register address width.
- FLAG_W, 4, number of flag bits taken from the result LSBs.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- aluDataIn  in  DATA_W  ALU result from pipeline register
- memoryDataIn  in  DATA_W  memory read data from pipeline register
- memoryReadIn  in  1  select memory data
- wbIn  in  1  register write request
- rDstIn  in  RADDR_W  destination register
- writeFlagIn  in  1  flag restore request
- writePcHighIn  in  1  PC high-half beat
- writePcLowIn  in  1  PC low-half beat
- inInstIn  in  1  IN instruction
- outInstIn  in  1  OUT instruction
- inPort  in  DATA_W  external input port
- outReady  in  1  external sink ready
- regWrEn  out  1  register-file write enable
- regWrAddr  out  RADDR_W  write address
- regWrData  out  DATA_W  write data
- flagWrEn  out  1  flag write enable
- flagWrData  out  FLAG_W  flag value
- pcLoadEn  out  1  PC load strobe
- pcLoadValue  out  2*DATA_W  new PC
- outPort  out  DATA_W  output port data (registered)
- outValid  out  1  outPort holds unconsumed data
- stall  out  1  hold pipeline register contents
- pcSeqErr  out  1  sticky PC-sequence error

Behaviour:
- Clocking: single clock domain, rising edge. Asynchronous active-low reset.
- Reset state: all registered state is 0.
  - outPort=0, outValid=0, pcSeqErr=0, inLatch=0, pcHighReg=0.
  - FSM in PC_IDLE.
- Input sampling: inLatch samples inPort every cycle (1-cycle latency).
- Result select (combinational), selData:
  - inLatch when inInstIn=1;
  - else memoryDataIn when memoryReadIn=1;
  - else aluDataIn.
- stall (combinational) = outInstIn & outValid & ~outReady. While stall=1:
  - all writes are suppressed: regWrEn, flagWrEn, pcLoadEn, FSM update, outPort update;
  - upstream holds inputs; the instruction is replayed the next cycle.
- Register write: regWrEn = wbIn & ~stall; regWrAddr = rDstIn; regWrData = selData. Same cycle as the inputs (combinational).
- Flag write: flagWrEn = writeFlagIn & ~stall; flagWrData = selData[FLAG_W-1:0].
- PC FSM has two states, PC_IDLE and PC_HAVE_HIGH:
  - PC_IDLE, writePcHighIn only: pcHighReg <= selData; go to PC_HAVE_HIGH.
  - PC_HAVE_HIGH, writePcLowIn only: pcLoadEn=1 (combinational); pcLoadValue = {pcHighReg, selData}; go to PC_IDLE.
  - PC_HAVE_HIGH, writePcHighIn again: overwrite pcHighReg; stay in PC_HAVE_HIGH; no error.
  - PC_IDLE, writePcLowIn: no load; set pcSeqErr.
  - writePcHighIn and writePcLowIn in the same cycle: no load; set pcSeqErr; go to PC_IDLE.
  - Neither beat: hold state.
- pcLoadValue when pcLoadEn=0: {pcHighReg, selData}, don't-care for consumers.
- pcSeqErr: cleared only by reset.
- Output port:
  - Accepted OUT (outInstIn & ~stall): outPort <= selData; outValid <= 1.
  - outValid & outReady with no new OUT: outValid <= 0 next cycle.
  - outValid & outReady with a simultaneous OUT: outPort is replaced, outValid stays 1. This gives back-to-back throughput of 1 per cycle.
  - outPort is stable while outValid & ~outReady.
- Reset mid-sequence: a pending high half is discarded and a pending outPort is dropped (outValid=0).
- Widths: no arithmetic in this block; all fields pass through at their declared widths.

Optional Feature:
- Macro: WB_IN_SYNC_EN.
- Defined: inPort passes through a 2-flop synchronizer before inLatch. IN-instruction data lags inPort by 3 cycles. Synchronizer flops reset to 0.
- Undefined: single inLatch register, 1-cycle lag.
- All other behaviour is identical.

Test Plan:
- Reset: assert rst_n=0 mid-operation with outValid=1 and FSM in PC_HAVE_HIGH → all outputs 0, FSM PC_IDLE. Then writePcLowIn=1 → pcSeqErr=1, pcLoadEn=0.
- Select: aluDataIn=0x1234, memoryDataIn=0xBEEF, wbIn=1, rDstIn=5.
  - memoryReadIn=0 → regWrData=0x1234, regWrAddr=5.
  - memoryReadIn=1 → regWrData=0xBEEF.
  - inPort=0x00A5 held ≥3 cycles, inInstIn=1 → regWrData=0x00A5.
- PC reload: cycle 0 writePcHighIn with data 0x0001; cycle 1 writePcLowIn with data 0x2000 → cycle 1 pcLoadEn=1, pcLoadValue=0x00012000. Cycle 2 pcLoadEn=0, FSM PC_IDLE.
- Output back-pressure: OUT 0x0055 with outReady=0 → outValid=1, outPort=0x0055. Next OUT 0x0066 → stall=1 and regWrEn=0 until outReady=1. Then outPort=0x0066 on the following edge.
- Flag restore: writeFlagIn=1, selData=0x000B → flagWrEn=1, flagWrData=4'hB. The same with stall=1 → flagWrEn=0.
- Simultaneous PC beats: writePcHighIn=writePcLowIn=1 → pcLoadEn=0, pcSeqErr=1 sticky across 10 cycles.

Source files
------------

// File: rtl/wb_stage_unit.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage_unit
// Purpose  : Writeback stage: result select, register/flag/PC writes, and a
//            valid/ready output port. WB_IN_SYNC_EN adds an inPort synchronizer.
// Revision : 1.0
// ============================================================================
module wb_stage_unit #(
  parameter int DATA_W  = 16,
  parameter int RADDR_W = 3,
  parameter int FLAG_W  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   aluDataIn,
  input  logic [DATA_W-1:0]   memoryDataIn,
  input  logic                memoryReadIn,
  input  logic                wbIn,
  input  logic [RADDR_W-1:0]  rDstIn,
  input  logic                writeFlagIn,
  input  logic                writePcHighIn,
  input  logic                writePcLowIn,
  input  logic                inInstIn,
  input  logic                outInstIn,
  input  logic [DATA_W-1:0]   inPort,
  input  logic                outReady,
  output logic                regWrEn,
  output logic [RADDR_W-1:0]  regWrAddr,
  output logic [DATA_W-1:0]   regWrData,
  output logic                flagWrEn,
  output logic [FLAG_W-1:0]   flagWrData,
  output logic                pcLoadEn,
  output logic [2*DATA_W-1:0] pcLoadValue,
  output logic [DATA_W-1:0]   outPort,
  output logic                outValid,
  output logic                stall,
  output logic                pcSeqErr
);

  typedef enum logic [0:0] {
    PC_IDLE      = 1'b0,
    PC_HAVE_HIGH = 1'b1
  } pc_state_t;

  pc_state_t           r_state;
  pc_state_t           w_stateNext;
  logic [DATA_W-1:0]   r_inLatch;
  logic [DATA_W-1:0]   r_pcHigh;
  logic [DATA_W-1:0]   w_pcHighNext;
  logic [DATA_W-1:0]   r_outPort;
  logic                r_outValid;
  logic                r_pcSeqErr;
  logic                w_errSet;
  logic                w_pcLoad;
  logic                w_stall;
  logic [DATA_W-1:0]   w_selData;

`ifdef WB_IN_SYNC_EN
  logic [DATA_W-1:0]   r_sync1;
  logic [DATA_W-1:0]   r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_inLatch <= '0;
    end else begin
      r_sync1   <= inPort;
      r_sync2   <= r_sync1;
      r_inLatch <= r_sync2;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_inLatch <= '0;
    else        r_inLatch <= inPort;
  end
`endif

  assign w_selData = inInstIn     ? r_inLatch    :
                     memoryReadIn ? memoryDataIn : aluDataIn;

  // A new OUT cannot be accepted while the previous value is still unconsumed.
  assign w_stall = outInstIn & r_outValid & ~outReady;

  assign regWrEn     = wbIn & ~w_stall;
  assign regWrAddr   = rDstIn;
  assign regWrData   = w_selData;
  assign flagWrEn    = writeFlagIn & ~w_stall;
  assign flagWrData  = w_selData[FLAG_W-1:0];
  assign pcLoadEn    = w_pcLoad;
  assign pcLoadValue = {r_pcHigh, w_selData};
  assign outPort     = r_outPort;
  assign outValid    = r_outValid;
  assign stall       = w_stall;
  assign pcSeqErr    = r_pcSeqErr;

  always_comb begin
    w_stateNext  = r_state;
    w_pcHighNext = r_pcHigh;
    w_errSet     = 1'b0;
    w_pcLoad     = 1'b0;
    if (!w_stall) begin
      if (writePcHighIn && writePcLowIn) begin
        w_errSet    = 1'b1;
        w_stateNext = PC_IDLE;
      end else if (writePcHighIn) begin
        w_pcHighNext = w_selData;
        w_stateNext  = PC_HAVE_HIGH;
      end else if (writePcLowIn) begin
        if (r_state == PC_HAVE_HIGH) begin
          w_pcLoad    = 1'b1;
          w_stateNext = PC_IDLE;
        end else begin
          w_errSet = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= PC_IDLE;
      r_pcHigh   <= '0;
      r_pcSeqErr <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_pcHigh   <= w_pcHighNext;
      r_pcSeqErr <= r_pcSeqErr | w_errSet;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outPort  <= '0;
      r_outValid <= 1'b0;
    end else if (!w_stall) begin
      if (outInstIn) begin
        r_outPort  <= w_selData;
        r_outValid <= 1'b1;
      end else if (outReady) begin
        r_outValid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_stage_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_stage_unit
// Purpose  : Self-checking bench for wb_stage_unit: directed scenarios plus
//            randomized traffic against a behavioural reference model.
// Revision : 1.0
// ============================================================================
module tb_wb_stage_unit;

  localparam int DATA_W  = 16;
  localparam int RADDR_W = 3;
  localparam int FLAG_W  = 4;
`ifdef WB_IN_SYNC_EN
  localparam int LAG = 3;
`else
  localparam int LAG = 1;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [DATA_W-1:0]   aluDataIn = '0, memoryDataIn = '0, inPort = '0;
  logic                memoryReadIn = 0, wbIn = 0, writeFlagIn = 0;
  logic                writePcHighIn = 0, writePcLowIn = 0;
  logic                inInstIn = 0, outInstIn = 0, outReady = 0;
  logic [RADDR_W-1:0]  rDstIn = '0;
  logic                regWrEn, flagWrEn, pcLoadEn, outValid, stall, pcSeqErr;
  logic [RADDR_W-1:0]  regWrAddr;
  logic [DATA_W-1:0]   regWrData, outPort;
  logic [FLAG_W-1:0]   flagWrData;
  logic [2*DATA_W-1:0] pcLoadValue;

  wb_stage_unit #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .FLAG_W(FLAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .aluDataIn(aluDataIn), .memoryDataIn(memoryDataIn), .memoryReadIn(memoryReadIn),
    .wbIn(wbIn), .rDstIn(rDstIn), .writeFlagIn(writeFlagIn),
    .writePcHighIn(writePcHighIn), .writePcLowIn(writePcLowIn),
    .inInstIn(inInstIn), .outInstIn(outInstIn), .inPort(inPort), .outReady(outReady),
    .regWrEn(regWrEn), .regWrAddr(regWrAddr), .regWrData(regWrData),
    .flagWrEn(flagWrEn), .flagWrData(flagWrData),
    .pcLoadEn(pcLoadEn), .pcLoadValue(pcLoadValue),
    .outPort(outPort), .outValid(outValid), .stall(stall), .pcSeqErr(pcSeqErr)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  logic [DATA_W-1:0] hist[$];
  bit                m_valid, m_haveHigh, m_err;
  logic [DATA_W-1:0] m_port, m_high;

  task automatic model_reset();
    hist.delete();
    repeat (LAG) hist.push_back('0);
    m_valid = 0; m_haveHigh = 0; m_err = 0; m_port = '0; m_high = '0;
  endtask

  function automatic logic [DATA_W-1:0] exp_sel();
    if (inInstIn)     return hist[0];
    if (memoryReadIn) return memoryDataIn;
    return aluDataIn;
  endfunction

  // Compare everything against the model, advance the model, move to next negedge.
  task automatic step();
    logic [DATA_W-1:0] sel;
    bit st, ld;
    #1;
    sel = exp_sel();
    st  = outInstIn && m_valid && !outReady;
    ld  = !st && m_haveHigh && writePcLowIn && !writePcHighIn;
    check("stall",       stall,       st);
    check("regWrEn",     regWrEn,     wbIn && !st);
    check("regWrAddr",   regWrAddr,   rDstIn);
    check("regWrData",   regWrData,   sel);
    check("flagWrEn",    flagWrEn,    writeFlagIn && !st);
    check("flagWrData",  flagWrData,  sel % 16);
    check("pcLoadEn",    pcLoadEn,    ld);
    check("pcLoadValue", pcLoadValue, (64'(m_high) << DATA_W) | 64'(sel));
    check("outValid",    outValid,    m_valid);
    check("outPort",     outPort,     m_port);
    check("pcSeqErr",    pcSeqErr,    m_err);
    if (!st) begin
      if (writePcHighIn && writePcLowIn) begin m_err = 1; m_haveHigh = 0; end
      else if (writePcHighIn) begin m_high = sel; m_haveHigh = 1; end
      else if (writePcLowIn) begin
        if (m_haveHigh) m_haveHigh = 0;
        else            m_err = 1;
      end
      if (outInstIn) begin m_port = sel; m_valid = 1; end
      else if (outReady) m_valid = 0;
    end
    hist.push_back(inPort);
    void'(hist.pop_front());
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    aluDataIn = '0; memoryDataIn = '0; memoryReadIn = 0; wbIn = 0; rDstIn = '0;
    writeFlagIn = 0; writePcHighIn = 0; writePcLowIn = 0;
    inInstIn = 0; outInstIn = 0; outReady = 0; inPort = '0;
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1;
    check("rst_outValid", outValid, 0);
    check("rst_outPort",  outPort,  0);
    check("rst_pcSeqErr", pcSeqErr, 0);
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    idle_inputs();
    model_reset();
    @(negedge clk);
    do_reset();
    #1;
    check("init_pcLoadEn", pcLoadEn, 0);
    step();

    // Result select
    aluDataIn = 16'h1234; memoryDataIn = 16'hBEEF; wbIn = 1; rDstIn = 3'd5;
    #1; check("sel_alu", regWrData, 16'h1234); check("sel_addr", regWrAddr, 5);
    step();
    memoryReadIn = 1;
    #1; check("sel_mem", regWrData, 16'hBEEF);
    step();
    inPort = 16'h00A5;
    repeat (3) step();
    inInstIn = 1;
    #1; check("sel_in", regWrData, 16'h00A5);
    step();
    idle_inputs(); inPort = 16'h00A5;

    // PC reload
    writePcHighIn = 1; aluDataIn = 16'h0001;
    step();
    writePcHighIn = 0; writePcLowIn = 1; aluDataIn = 16'h2000;
    #1; check("pc_load", pcLoadEn, 1); check("pc_value", pcLoadValue, 32'h0001_2000);
    step();
    writePcLowIn = 0;
    #1; check("pc_load_after", pcLoadEn, 0);
    step();

    // Output back-pressure
    outInstIn = 1; aluDataIn = 16'h0055; outReady = 0; wbIn = 1;
    step();
    #1; check("bp_valid", outValid, 1); check("bp_port", outPort, 16'h0055);
    aluDataIn = 16'h0066;
    #1; check("bp_stall", stall, 1); check("bp_regWrEn", regWrEn, 0);
    step(); step();
    #1; check("bp_port_hold", outPort, 16'h0055);
    outReady = 1;
    #1; check("bp_release", stall, 0);
    step();
    #1; check("bp_port_new", outPort, 16'h0066);
    outInstIn = 0; wbIn = 0;
    step();
    #1; check("bp_drain", outValid, 0);

    // Flag restore
    writeFlagIn = 1; aluDataIn = 16'h000B; outReady = 0;
    #1; check("flag_en", flagWrEn, 1); check("flag_data", flagWrData, 4'hB);
    writeFlagIn = 0; outInstIn = 1;
    step();
    writeFlagIn = 1;
    #1; check("flag_stalled", flagWrEn, 0);
    step();
    idle_inputs(); outReady = 1;
    step();

    // Reset mid-sequence
    writePcHighIn = 1; aluDataIn = 16'h7777;
    step();
    writePcHighIn = 0; outInstIn = 1; outReady = 0; aluDataIn = 16'h0099;
    step();
    #1; check("mid_valid", outValid, 1);
    do_reset();
    writePcLowIn = 1;
    #1; check("mid_noload", pcLoadEn, 0);
    step();
    writePcLowIn = 0;
    #1; check("mid_seqerr", pcSeqErr, 1);
    step();

    // Simultaneous beats, sticky error
    do_reset();
    writePcHighIn = 1; writePcLowIn = 1;
    #1; check("both_noload", pcLoadEn, 0);
    step();
    writePcHighIn = 0; writePcLowIn = 0;
    for (int i = 0; i < 10; i++) begin
      #1; check("both_sticky", pcSeqErr, 1);
      step();
    end

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      aluDataIn     = 16'($urandom);
      memoryDataIn  = 16'($urandom);
      inPort        = 16'($urandom);
      memoryReadIn  = 1'($urandom);
      wbIn          = 1'($urandom);
      rDstIn        = 3'($urandom);
      writeFlagIn   = ($urandom_range(0, 3) == 0);
      writePcHighIn = ($urandom_range(0, 4) == 0);
      writePcLowIn  = ($urandom_range(0, 4) == 0);
      inInstIn      = ($urandom_range(0, 3) == 0);
      outInstIn     = ($urandom_range(0, 2) == 0);
      outReady      = 1'($urandom);
      if (i % 500 == 250) do_reset();
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
